cv32e40p_tb_ram_arbiter: RTL and testbench

CV32E40P_TB_RAM_ARBITER -- requirements
Module: cv32e40p_tb_ram_arbiter

---
 rtl/cv32e40p_tb_pkg.sv | 26 ++
 rtl/cv32e40p_tb_rr_arb2.sv | 61 ++++++
 rtl/cv32e40p_tb_ram_arbiter.sv | 127 ++++++++++++
 tb/tb_cv32e40p_tb_ram_arbiter.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cv32e40p_tb_pkg.sv
// Shared types for the testbench RAM arbiter.
//   port_sel_e : identifies the instruction or the data OBI port
//   resp_t     : response-routing entry carried from the grant cycle to the response cycle
//   addr_in_range : true when the byte address falls inside the RAM window
package cv32e40p_tb_pkg;

    typedef enum logic {
        PORT_INSTR = 1'b0,
        PORT_DATA  = 1'b1
    } port_sel_e;

    typedef struct packed {
        logic      valid;  // a response is due this cycle
        port_sel_e port;   // port that owns the response
        logic      oor;    // access fell outside the RAM window
        logic      we;     // access was a write, so no read data is returned
    } resp_t;

    localparam resp_t RESP_IDLE = '{valid: 1'b0, port: PORT_INSTR, oor: 1'b0, we: 1'b0};

    // Address is inside the RAM when every bit at or above aw is zero.
    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned aw);
        return ((addr >> aw) == 32'd0);
    endfunction

endpackage

// File: rtl/cv32e40p_tb_rr_arb2.sv
// Two-way round-robin arbiter between the instruction and data ports.
//   clk_i, rst_ni             : clock, asynchronous active-low reset
//   req_instr_i, req_data_i   : requests
//   gnt_instr_o, gnt_data_o   : same-cycle grants, at most one high, both low in reset
// prio_q names the port that wins a conflict; it always moves to the port that
// was not granted, so a waiting requester wins the very next cycle.
module cv32e40p_tb_rr_arb2
    import cv32e40p_tb_pkg::*;
(
    input  logic clk_i,
    input  logic rst_ni,
    input  logic req_instr_i,
    input  logic req_data_i,
    output logic gnt_instr_o,
    output logic gnt_data_o
);

    port_sel_e prio_q;
    logic      gnt_instr_s;
    logic      gnt_data_s;

    // Grant decision: a lone requester always wins, a conflict is settled by prio_q.
    always_comb begin
        gnt_instr_s = 1'b0;
        gnt_data_s  = 1'b0;
        if (!rst_ni) begin
            gnt_instr_s = 1'b0;
            gnt_data_s  = 1'b0;
        end else if (req_instr_i && req_data_i) begin
            if (prio_q == PORT_DATA) begin
                gnt_data_s = 1'b1;
            end else begin
                gnt_instr_s = 1'b1;
            end
        end else if (req_instr_i) begin
            gnt_instr_s = 1'b1;
        end else if (req_data_i) begin
            gnt_data_s = 1'b1;
        end else begin
            gnt_instr_s = 1'b0;
            gnt_data_s  = 1'b0;
        end
    end

    // Priority register: after every grant point at the port that lost out.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q <= PORT_INSTR;
        end else if (gnt_instr_s) begin
            prio_q <= PORT_DATA;
        end else if (gnt_data_s) begin
            prio_q <= PORT_INSTR;
        end else begin
            prio_q <= prio_q;
        end
    end

    assign gnt_instr_o = gnt_instr_s;
    assign gnt_data_o  = gnt_data_s;

endmodule

// File: rtl/cv32e40p_tb_ram_arbiter.sv
// Shares one single-port RAM between the OBI instruction and data ports.
//   clk_i, rst_ni                         : clock, asynchronous active-low reset
//   instr_req_i/gnt_o/addr_i/rvalid_o/rdata_o : read-only instruction port
//   data_req_i/gnt_o/addr_i/we_i/be_i/wdata_i/rvalid_o/rdata_o/err_o : data port
//   ram_en_o/we_o/be_o/addr_o/wdata_o, ram_rdata_i : RAM command, read data one cycle later
//   conflict_cnt_o                        : saturating count of cycles with both ports requesting
// Grants and the RAM command are combinational from the requests; the response
// comes from a one-entry routing register so back-to-back grants need no bubble.
module cv32e40p_tb_ram_arbiter
    import cv32e40p_tb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 22
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  instr_req_i,
    output logic                  instr_gnt_o,
    input  logic [31:0]           instr_addr_i,
    output logic                  instr_rvalid_o,
    output logic [31:0]           instr_rdata_o,
    input  logic                  data_req_i,
    output logic                  data_gnt_o,
    input  logic [31:0]           data_addr_i,
    input  logic                  data_we_i,
    input  logic [3:0]            data_be_i,
    input  logic [31:0]           data_wdata_i,
    output logic                  data_rvalid_o,
    output logic [31:0]           data_rdata_o,
    output logic                  data_err_o,
    output logic                  ram_en_o,
    output logic                  ram_we_o,
    output logic [3:0]            ram_be_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [31:0]           ram_wdata_o,
    input  logic [31:0]           ram_rdata_i,
    output logic [31:0]           conflict_cnt_o
);

    logic                  gnt_instr_s;
    logic                  gnt_data_s;
    logic                  instr_inr_s;
    logic                  data_inr_s;
    logic                  ram_en_s;
    logic                  ram_we_s;
    logic [3:0]            ram_be_s;
    logic [ADDR_WIDTH-1:0] ram_addr_s;
    logic [31:0]           ram_wdata_s;
    resp_t                 resp_d_s;
    resp_t                 resp_r;
    logic [31:0]           conflict_cnt_r;
    logic                  rd_data_ok_s;

    cv32e40p_tb_rr_arb2 u_rr_arb2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .req_instr_i (instr_req_i),
        .req_data_i  (data_req_i),
        .gnt_instr_o (gnt_instr_s),
        .gnt_data_o  (gnt_data_s)
    );

    assign instr_inr_s = addr_in_range(instr_addr_i, ADDR_WIDTH);
    assign data_inr_s  = addr_in_range(data_addr_i, ADDR_WIDTH);

    // RAM command mux and next routing entry; out-of-range grants never touch the RAM.
    always_comb begin
        ram_en_s    = 1'b0;
        ram_we_s    = 1'b0;
        ram_be_s    = 4'h0;
        ram_addr_s  = '0;
        ram_wdata_s = 32'h0000_0000;
        resp_d_s    = RESP_IDLE;
        if (gnt_instr_s) begin
            ram_en_s   = instr_inr_s;
            ram_be_s   = 4'hF;
            ram_addr_s = instr_addr_i[ADDR_WIDTH-1:0];
            resp_d_s   = '{valid: 1'b1, port: PORT_INSTR, oor: ~instr_inr_s, we: 1'b0};
        end else if (gnt_data_s) begin
            ram_en_s    = data_inr_s;
            ram_we_s    = data_we_i;
            ram_be_s    = data_be_i;
            ram_addr_s  = data_addr_i[ADDR_WIDTH-1:0];
            ram_wdata_s = data_wdata_i;
            resp_d_s    = '{valid: 1'b1, port: PORT_DATA, oor: ~data_inr_s, we: data_we_i};
        end else begin
            resp_d_s = RESP_IDLE;
        end
    end

    // Response routing register; reset drops any response still in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            resp_r <= RESP_IDLE;
        end else begin
            resp_r <= resp_d_s;
        end
    end

    // Conflict counter, saturating at all-ones.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            conflict_cnt_r <= 32'h0000_0000;
        end else if (instr_req_i && data_req_i && (conflict_cnt_r != 32'hFFFF_FFFF)) begin
            conflict_cnt_r <= conflict_cnt_r + 32'd1;
        end else begin
            conflict_cnt_r <= conflict_cnt_r;
        end
    end

    // Only in-range reads return RAM data; writes and out-of-range accesses return zero.
    assign rd_data_ok_s   = ~resp_r.oor & ~resp_r.we;
    assign instr_rvalid_o = resp_r.valid & (resp_r.port == PORT_INSTR);
    assign data_rvalid_o  = resp_r.valid & (resp_r.port == PORT_DATA);
    assign instr_rdata_o  = (instr_rvalid_o && rd_data_ok_s) ? ram_rdata_i : 32'h0000_0000;
    assign data_rdata_o   = (data_rvalid_o && rd_data_ok_s) ? ram_rdata_i : 32'h0000_0000;
    assign data_err_o     = data_rvalid_o & resp_r.oor;

    assign instr_gnt_o    = gnt_instr_s;
    assign data_gnt_o     = gnt_data_s;
    assign ram_en_o       = ram_en_s;
    assign ram_we_o       = ram_we_s;
    assign ram_be_o       = ram_be_s;
    assign ram_addr_o     = ram_addr_s;
    assign ram_wdata_o    = ram_wdata_s;
    assign conflict_cnt_o = conflict_cnt_r;

endmodule

// File: tb/tb_cv32e40p_tb_ram_arbiter.sv
// Self-checking bench for cv32e40p_tb_ram_arbiter: a RAM model answers the
// DUT's RAM port, a reference arbiter model predicts grants and the conflict
// count, and expected responses queue up per port until the DUT delivers them.
module tb_cv32e40p_tb_ram_arbiter;

    localparam int unsigned AW = 22;

    typedef struct {
        logic [31:0] rdata;
        logic        err;
    } exp_t;

    logic          clk;
    logic          rst_ni;
    logic          instr_req, instr_gnt, instr_rvalid;
    logic [31:0]   instr_addr, instr_rdata;
    logic          data_req, data_gnt, data_we, data_rvalid, data_err;
    logic [31:0]   data_addr, data_wdata, data_rdata;
    logic [3:0]    data_be;
    logic          ram_en, ram_we;
    logic [3:0]    ram_be;
    logic [AW-1:0] ram_addr;
    logic [31:0]   ram_wdata, ram_rdata, conflict_cnt;

    logic [31:0]   mem     [256];
    logic [31:0]   exp_mem [256];
    exp_t          iq[$];
    exp_t          dq[$];
    exp_t          e_mon;
    logic          prio_m;
    logic [31:0]   cnt_m;
    int            n_checks;
    int            n_fail;

    cv32e40p_tb_ram_arbiter #(.ADDR_WIDTH(AW)) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .instr_req_i    (instr_req),
        .instr_gnt_o    (instr_gnt),
        .instr_addr_i   (instr_addr),
        .instr_rvalid_o (instr_rvalid),
        .instr_rdata_o  (instr_rdata),
        .data_req_i     (data_req),
        .data_gnt_o     (data_gnt),
        .data_addr_i    (data_addr),
        .data_we_i      (data_we),
        .data_be_i      (data_be),
        .data_wdata_i   (data_wdata),
        .data_rvalid_o  (data_rvalid),
        .data_rdata_o   (data_rdata),
        .data_err_o     (data_err),
        .ram_en_o       (ram_en),
        .ram_we_o       (ram_we),
        .ram_be_o       (ram_be),
        .ram_addr_o     (ram_addr),
        .ram_wdata_o    (ram_wdata),
        .ram_rdata_i    (ram_rdata),
        .conflict_cnt_o (conflict_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single-port RAM model, one-cycle read latency, byte-enabled writes.
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we) begin
                for (int b = 0; b < 4; b++) begin
                    if (ram_be[b]) mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
                end
            end
            ram_rdata <= mem[ram_addr[9:2]];
        end
    end

    // Response scoreboard: every rvalid must match the oldest expected entry of its port.
    always @(negedge clk) begin
        if (rst_ni) begin
            n_checks++;
            if (instr_rvalid) begin
                if (iq.size() == 0) begin
                    n_fail++;
                    $display("FAIL instr_rvalid_unexpected: got rvalid=1 required no response pending");
                end else begin
                    e_mon = iq.pop_front();
                    if (instr_rdata !== e_mon.rdata) begin
                        n_fail++;
                        $display("FAIL instr_rdata: got %h required %h", instr_rdata, e_mon.rdata);
                    end
                end
            end else if (instr_rdata !== 32'h0) begin
                n_fail++;
                $display("FAIL instr_rdata_idle: got %h required 00000000", instr_rdata);
            end
            n_checks++;
            if (data_rvalid) begin
                if (dq.size() == 0) begin
                    n_fail++;
                    $display("FAIL data_rvalid_unexpected: got rvalid=1 required no response pending");
                end else begin
                    e_mon = dq.pop_front();
                    if ((data_rdata !== e_mon.rdata) || (data_err !== e_mon.err)) begin
                        n_fail++;
                        $display("FAIL data_resp: got rdata=%h err=%b required rdata=%h err=%b",
                                 data_rdata, data_err, e_mon.rdata, e_mon.err);
                    end
                end
            end else if ((data_rdata !== 32'h0) || (data_err !== 1'b0)) begin
                n_fail++;
                $display("FAIL data_resp_idle: got rdata=%h err=%b required 0/0", data_rdata, data_err);
            end
        end
    end

    // One arbitration cycle: drive at the falling edge, check grant and RAM command,
    // queue the expected response, then advance to the next falling edge.
    task automatic step(input logic ireq, input logic [31:0] iaddr,
                        input logic dreq, input logic [31:0] daddr,
                        input logic dwe, input logic [3:0] dbe, input logic [31:0] dwdata);
        logic exp_gi, exp_gd, inr;
        logic [7:0] idx;
        exp_t e;
        instr_req = ireq; instr_addr = iaddr;
        data_req = dreq; data_addr = daddr; data_we = dwe; data_be = dbe; data_wdata = dwdata;
        #1;
        exp_gi = ireq & (~dreq | (prio_m == 1'b0));
        exp_gd = dreq & (~ireq | (prio_m == 1'b1));
        n_checks++;
        if ((instr_gnt !== exp_gi) || (data_gnt !== exp_gd)) begin
            n_fail++;
            $display("FAIL grant: got i=%b d=%b required i=%b d=%b", instr_gnt, data_gnt, exp_gi, exp_gd);
        end
        if (exp_gi) begin
            inr = ((iaddr >> AW) == 32'd0);
            idx = iaddr[9:2];
            n_checks++;
            if ((ram_en !== inr) || (inr && ((ram_addr !== iaddr[AW-1:0]) || (ram_we !== 1'b0) || (ram_be !== 4'hF)))) begin
                n_fail++;
                $display("FAIL instr_ram_cmd: got en=%b we=%b be=%h addr=%h required en=%b we=0 be=f addr=%h",
                         ram_en, ram_we, ram_be, ram_addr, inr, iaddr[AW-1:0]);
            end
            e.rdata = inr ? exp_mem[idx] : 32'h0;
            e.err = 1'b0;
            iq.push_back(e);
            prio_m = 1'b1;
        end else if (exp_gd) begin
            inr = ((daddr >> AW) == 32'd0);
            idx = daddr[9:2];
            n_checks++;
            if ((ram_en !== inr) || (inr && ((ram_addr !== daddr[AW-1:0]) || (ram_we !== dwe) || (ram_be !== dbe) ||
                                             (dwe && (ram_wdata !== dwdata))))) begin
                n_fail++;
                $display("FAIL data_ram_cmd: got en=%b we=%b be=%h addr=%h wd=%h required en=%b we=%b be=%h addr=%h wd=%h",
                         ram_en, ram_we, ram_be, ram_addr, ram_wdata, inr, dwe, dbe, daddr[AW-1:0], dwdata);
            end
            if (inr && dwe) begin
                for (int b = 0; b < 4; b++) begin
                    if (dbe[b]) exp_mem[idx][8*b +: 8] = dwdata[8*b +: 8];
                end
            end
            e.rdata = (inr && !dwe) ? exp_mem[idx] : 32'h0;
            e.err = ~inr;
            dq.push_back(e);
            prio_m = 1'b0;
        end else begin
            n_checks++;
            if (ram_en !== 1'b0) begin
                n_fail++;
                $display("FAIL ram_en_idle: got %b required 0", ram_en);
            end
        end
        if (ireq && dreq && (cnt_m != 32'hFFFF_FFFF)) cnt_m = cnt_m + 32'd1;
        @(posedge clk);
        @(negedge clk);
        n_checks++;
        if (conflict_cnt !== cnt_m) begin
            n_fail++;
            $display("FAIL conflict_cnt: got %h required %h", conflict_cnt, cnt_m);
        end
    endtask

    task automatic idle();
        step(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        instr_req = 1'b1; instr_addr = 32'h80;
        data_req = 1'b1; data_addr = 32'h100; data_we = 1'b0; data_be = 4'hF; data_wdata = 32'h0;
        for (int k = 0; k < 2; k++) begin
            #1;
            n_checks++;
            if ({instr_gnt, data_gnt, ram_en, instr_rvalid, data_rvalid, data_err} !== 6'b0 || conflict_cnt !== 32'h0) begin
                n_fail++;
                $display("FAIL reset_outputs: got gnt=%b%b en=%b rv=%b%b err=%b cnt=%h required all 0",
                         instr_gnt, data_gnt, ram_en, instr_rvalid, data_rvalid, data_err, conflict_cnt);
            end
            @(negedge clk);
        end
        instr_req = 1'b0; data_req = 1'b0;
        rst_ni = 1'b1;
        prio_m = 1'b0; cnt_m = 32'h0;
    endtask

    task automatic test_alternate();
        for (int k = 0; k < 4; k++) step(1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        idle();
    endtask

    task automatic test_instr_read();
        step(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        n_checks++;
        if ((instr_rvalid !== 1'b1) || (instr_rdata !== 32'h0000_0013)) begin
            n_fail++;
            $display("FAIL instr_read_0x80: got rvalid=%b rdata=%h required 1/00000013", instr_rvalid, instr_rdata);
        end
        // priority now favours data: the next conflict must grant data
        step(1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        idle();
    endtask

    task automatic test_write_read();
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b1, 4'b0011, 32'hDEAD_BEEF);
        n_checks++;
        if ((data_rvalid !== 1'b1) || (data_rdata !== 32'h0)) begin
            n_fail++;
            $display("FAIL write_resp: got rvalid=%b rdata=%h required 1/00000000", data_rvalid, data_rdata);
        end
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        n_checks++;
        if ((data_rvalid !== 1'b1) || (data_rdata !== 32'h0000_BEEF)) begin
            n_fail++;
            $display("FAIL readback: got rvalid=%b rdata=%h required 1/0000beef", data_rvalid, data_rdata);
        end
        idle();
    endtask

    task automatic test_out_of_range();
        step(1'b0, 32'h0, 1'b1, 32'h1A11_0800, 1'b0, 4'hF, 32'h0);
        n_checks++;
        if ((data_rvalid !== 1'b1) || (data_err !== 1'b1) || (data_rdata !== 32'h0)) begin
            n_fail++;
            $display("FAIL oor_resp: got rvalid=%b err=%b rdata=%h required 1/1/00000000",
                     data_rvalid, data_err, data_rdata);
        end
        idle();
    endtask

    task automatic test_back_to_back();
        step(1'b1, 32'h80, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        step(1'b1, 32'h84, 1'b0, 32'h0, 1'b0, 4'h0, 32'h0);
        step(1'b0, 32'h0, 1'b1, 32'h104, 1'b1, 4'b1100, 32'h1234_5678);
        step(1'b0, 32'h0, 1'b1, 32'h104, 1'b0, 4'hF, 32'h0);
        idle();
    endtask

    task automatic test_reset_pending();
        instr_req = 1'b1; instr_addr = 32'h80; data_req = 1'b0;
        #1;
        n_checks++;
        if (instr_gnt !== 1'b1) begin
            n_fail++;
            $display("FAIL pre_reset_grant: got %b required 1", instr_gnt);
        end
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        instr_req = 1'b0;
        @(negedge clk);
        n_checks++;
        if ((instr_rvalid !== 1'b0) || (instr_rdata !== 32'h0)) begin
            n_fail++;
            $display("FAIL discarded_resp: got rvalid=%b rdata=%h required 0/00000000", instr_rvalid, instr_rdata);
        end
        rst_ni = 1'b1;
        prio_m = 1'b0; cnt_m = 32'h0;
        step(1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        idle();
    endtask

    task automatic test_saturate();
        force dut.conflict_cnt_r = 32'hFFFF_FFFE;
        #1;
        release dut.conflict_cnt_r;
        cnt_m = 32'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) step(1'b1, 32'h80, 1'b1, 32'h100, 1'b0, 4'hF, 32'h0);
        idle();
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        prio_m = 1'b0; cnt_m = 32'h0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = 32'h0;
            exp_mem[i] = 32'h0;
        end
        mem[32] = 32'h0000_0013;
        exp_mem[32] = 32'h0000_0013;
        test_reset();
        test_alternate();
        test_instr_read();
        test_write_read();
        test_out_of_range();
        test_back_to_back();
        test_reset_pending();
        test_saturate();
        #2;
        n_checks++;
        if ((iq.size() != 0) || (dq.size() != 0)) begin
            n_fail++;
            $display("FAIL responses_outstanding: got instr=%0d data=%0d required 0/0", iq.size(), dq.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
